// File: rtl/demux2_buffered.sv
// demux2_buffered: steers words from one shared source bus into CHANNELS
// holding registers, each with a valid/ack handshake to its consumer.
// A word aimed at an occupied, un-acked channel (or at a select beyond the
// last channel) is refused, flagged in a sticky overflow bit and counted.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in, select     source word and destination channel index
//   in_valid       source presents a word this cycle
//   in_ready       combinational: the presented word will be accepted
//   out            channel registers, channel i at [i*WIDTH +: WIDTH]
//   out_valid      per-channel word-held flags
//   out_ack        per-channel consumer acknowledge
//   overflow       sticky refused-word flag
//   overflow_clr   synchronous clear of overflow and drop_count
//   drop_count     saturating count of refused words
module demux2_buffered #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in,
    input  logic [SEL_WIDTH-1:0]      select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ack,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [7:0]                drop_count
);

    localparam int unsigned   CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] sel_hit;
    logic                accept;
    logic                refuse;

    // Decode select; an out-of-range select hits no channel and is never ready.
    always_comb begin
        sel_hit  = '0;
        in_ready = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (select == SEL_WIDTH'(i)) begin
                sel_hit[i] = 1'b1;
                in_ready   = ~out_valid[i] | out_ack[i];
            end
        end
    end

    assign accept = in_valid & in_ready;
    assign refuse = in_valid & ~in_ready;

    // Channel registers: a load takes priority over an ack so a same-cycle
    // ack + write passes the new word straight through with valid held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (accept && sel_hit[i]) begin
                    out[i*WIDTH +: WIDTH] <= in;
                    out_valid[i]          <= 1'b1;
                end else if (out_ack[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Refuse bookkeeping; a refuse in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (refuse) begin
            overflow <= 1'b1;
            if (overflow_clr) begin
                drop_count <= CNT_W'(1);
            end else if (drop_count != CNT_MAX) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_demux2_buffered.sv
// Bench for demux2_buffered: a 4-channel and a 3-channel instance share one
// stimulus stream; a queue-free array model tracks each and is compared on
// every falling edge, with literal checks at the key points of each scenario.
module tb_demux2_buffered;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in;
    logic [1:0]  select;
    logic        in_valid;
    logic [3:0]  out_ack;
    logic        overflow_clr;

    logic        in_ready4, in_ready3;
    logic [31:0] out4;
    logic [23:0] out3;
    logic [3:0]  out_valid4;
    logic [2:0]  out_valid3;
    logic        overflow4, overflow3;
    logic [7:0]  drop_count4, drop_count3;

    int nvec;
    int nerr;

    demux2_buffered #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in), .select(select), .in_valid(in_valid),
        .in_ready(in_ready4), .out(out4), .out_valid(out_valid4), .out_ack(out_ack),
        .overflow(overflow4), .overflow_clr(overflow_clr), .drop_count(drop_count4)
    );

    demux2_buffered #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in(in), .select(select), .in_valid(in_valid),
        .in_ready(in_ready3), .out(out3), .out_valid(out_valid3), .out_ack(out_ack[2:0]),
        .overflow(overflow3), .overflow_clr(overflow_clr), .drop_count(drop_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model: index 0 = 4-channel, 1 = 3-channel ----------
    logic [7:0] m_data [2][4];
    bit         m_valid[2][4];
    bit         m_ovf  [2];
    int         m_cnt  [2];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic bit model_ready(input int d);
        int s;
        s = int'(select);
        if (s >= nch(d)) return 1'b0;
        return !m_valid[d][s] || out_ack[s];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    m_data[d][c]  <= 8'h00;
                    m_valid[d][c] <= 1'b0;
                end
                m_ovf[d] <= 1'b0;
                m_cnt[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < nch(d); c++)
                    if (out_ack[c]) m_valid[d][c] <= 1'b0;
                if (in_valid && model_ready(d)) begin
                    m_data[d][select]  <= in;
                    m_valid[d][select] <= 1'b1;
                end
                if (in_valid && !model_ready(d)) begin
                    m_ovf[d] <= 1'b1;
                    m_cnt[d] <= overflow_clr ? 1 : ((m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1);
                end else if (overflow_clr) begin
                    m_ovf[d] <= 1'b0;
                    m_cnt[d] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- continuous compare against the model ---------------
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [31:0] eo, ev, ao, av, ar, af, ac;
                eo = '0;
                ev = '0;
                for (int c = 0; c < nch(d); c++) begin
                    eo[c*8 +: 8] = m_data[d][c];
                    ev[c]        = m_valid[d][c];
                end
                ao = (d == 0) ? out4 : {8'h00, out3};
                av = (d == 0) ? 32'(out_valid4) : 32'(out_valid3);
                ar = (d == 0) ? 32'(in_ready4) : 32'(in_ready3);
                af = (d == 0) ? 32'(overflow4) : 32'(overflow3);
                ac = (d == 0) ? 32'(drop_count4) : 32'(drop_count3);
                check($sformatf("d%0d out", d), ao, eo);
                check($sformatf("d%0d out_valid", d), av, ev);
                check($sformatf("d%0d in_ready", d), ar, 32'(model_ready(d)));
                check($sformatf("d%0d overflow", d), af, 32'(m_ovf[d]));
                check($sformatf("d%0d drop_count", d), ac, 32'(m_cnt[d]));
            end
        end
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic v,
                         input logic [3:0] a, input logic c);
        in = d; select = s; in_valid = v; out_ack = a; overflow_clr = c;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b0);
        #1;
        check("reset out", out4, 32'h0);
        check("reset out_valid", 32'(out_valid4), 32'h0);
        check("reset overflow", 32'(overflow4), 32'h0);
        check("reset in_ready", 32'(in_ready4), 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // basic fill
        drive(8'hAA, 2'd0, 1'b1, 4'b0000, 1'b0);
        #1 check("fill0 in_ready", 32'(in_ready4), 32'h1);
        edge_step();
        drive(8'h55, 2'd1, 1'b1, 4'b0000, 1'b0);
        #1 check("fill1 in_ready", 32'(in_ready4), 32'h1);
        edge_step();
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b0);
        check("fill ch0", 32'(out4[7:0]), 32'hAA);
        check("fill ch1", 32'(out4[15:8]), 32'h55);
        check("fill out_valid", 32'(out_valid4), 32'h3);
        check("fill overflow", 32'(overflow4), 32'h0);
        check("model fill ch1", 32'(m_data[0][1]), 32'h55);

        // blocked write
        drive(8'h55, 2'd0, 1'b1, 4'b0000, 1'b0);
        #1 check("blocked in_ready", 32'(in_ready4), 32'h0);
        edge_step();
        check("blocked ch0", 32'(out4[7:0]), 32'hAA);
        check("blocked overflow", 32'(overflow4), 32'h1);
        check("blocked drop_count", 32'(drop_count4), 32'h1);
        check("model drop_count", 32'(m_cnt[0]), 32'h1);
        repeat (300) edge_step();
        check("saturate drop_count", 32'(drop_count4), 32'hFF);
        check("saturate ch0", 32'(out4[7:0]), 32'hAA);

        // clear alone, then build up to 5, then clear collides with refuse
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b1);
        edge_step();
        check("clr overflow", 32'(overflow4), 32'h0);
        check("clr drop_count", 32'(drop_count4), 32'h0);
        drive(8'h66, 2'd0, 1'b1, 4'b0000, 1'b0);
        repeat (5) edge_step();
        check("five drop_count", 32'(drop_count4), 32'h5);
        drive(8'h66, 2'd0, 1'b1, 4'b0000, 1'b1);
        edge_step();
        check("collide overflow", 32'(overflow4), 32'h1);
        check("collide drop_count", 32'(drop_count4), 32'h1);
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b1);
        edge_step();
        check("clr2 overflow", 32'(overflow4), 32'h0);
        check("clr2 drop_count", 32'(drop_count4), 32'h0);

        // ack and write in the same cycle
        drive(8'h11, 2'd2, 1'b1, 4'b0000, 1'b0);
        edge_step();
        check("ch2 first", 32'(out4[23:16]), 32'h11);
        drive(8'h22, 2'd2, 1'b1, 4'b0100, 1'b0);
        #1 check("passthru in_ready", 32'(in_ready4), 32'h1);
        edge_step();
        check("passthru ch2", 32'(out4[23:16]), 32'h22);
        check("passthru valid2", 32'(out_valid4[2]), 32'h1);
        drive(8'h00, 2'd2, 1'b0, 4'b0100, 1'b0);
        edge_step();
        check("release valid2", 32'(out_valid4[2]), 32'h0);
        check("release ch2", 32'(out4[23:16]), 32'h22);

        // out-of-range select on the 3-channel instance
        drive(8'h77, 2'd3, 1'b1, 4'b0000, 1'b0);
        #1 check("oor in_ready3", 32'(in_ready3), 32'h0);
        check("oor in_ready4", 32'(in_ready4), 32'h1);
        edge_step();
        check("oor out3", 32'(out3), 32'h2255AA);
        check("oor overflow3", 32'(overflow3), 32'h1);
        check("oor ch3 of 4", 32'(out4[31:24]), 32'h77);

        // leave channels 0 and 3 valid, then reset between edges
        drive(8'h00, 2'd0, 1'b0, 4'b0010, 1'b0);
        edge_step();
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b0);
        check("pre-reset valid", 32'(out_valid4), 32'h9);
        #1 rst_n = 1'b0;
        #1;
        check("async out", out4, 32'h0);
        check("async out_valid", 32'(out_valid4), 32'h0);
        check("async overflow", 32'(overflow4), 32'h0);
        check("async overflow3", 32'(overflow3), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 drive(8'hAA, 2'd3, 1'b1, 4'b0000, 1'b0);
        edge_step();
        drive(8'h00, 2'd0, 1'b0, 4'b0000, 1'b0);
        check("post-reset ch3", 32'(out4[31:24]), 32'hAA);
        check("post-reset valid", 32'(out_valid4), 32'h8);
        check("post-reset overflow", 32'(overflow4), 32'h0);
        repeat (2) edge_step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
